// File: rtl/vidgen_pkg.sv
// Shared types and constants for the synthetic video source (vidgen).
// Optional LFSR noise pattern is selected by the VIDGEN_LFSR_EN macro.
package vidgen_pkg;

  localparam int PIX_W = 12;

  localparam logic [11:0] VIDGEN_LFSR_SEED = 12'hACE;
  // Taps for x^12 + x^6 + x^4 + x + 1 on a left-shifting register.
  localparam logic [11:0] VIDGEN_LFSR_TAPS = 12'h829;

  typedef enum logic [1:0] {
    PAT_XRAMP = 2'd0,
    PAT_YRAMP = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_LFSR  = 2'd3
  } vidgen_pattern_t;

  typedef enum logic {
    VG_IDLE = 1'b0,
    VG_RUN  = 1'b1
  } vidgen_state_t;

endpackage

// File: rtl/vidgen_lfsr.sv
// 12-bit Fibonacci LFSR used for the noise test pattern.
module vidgen_lfsr
  import vidgen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        seed_load,
  input  logic        advance,
  output logic [11:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= VIDGEN_LFSR_SEED;
    end else if (seed_load) begin
      q <= VIDGEN_LFSR_SEED;
    end else if (advance) begin
      q <= {q[10:0], ^(q & VIDGEN_LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/vidgen.sv
// Synthetic camera source: frame/line timing counters plus test-pattern pixels.
// Build with VIDGEN_LFSR_EN defined to get LFSR noise on pattern 3.
//
// Handshake: none; the stream is push-only. vid_pixsync marks the first clock
// of each slot and the consumer must take the pixel then; there is no ready.
module vidgen
  import vidgen_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_BLANK  = 32,
  parameter int V_ACTIVE = 240,
  parameter int V_BLANK  = 8,
  parameter int PIX_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [11:0] vid_pixel,
  output logic        vid_pixsync,
  output logic        vid_hblank,
  output logic        vid_vblank,
  output logic        vid_visible,
  output logic        frame_start,
  output logic [15:0] status_frame_count,
  output logic        dbg_state
);

  localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
  localparam logic [15:0] H_LAST = 16'(H_ACTIVE + H_BLANK - 1);
  localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
  localparam logic [15:0] V_LAST = 16'(V_ACTIVE + V_BLANK - 1);
  localparam logic [15:0] D_LAST = 16'(PIX_DIV - 1);

  vidgen_state_t   state, state_nxt;
  vidgen_pattern_t pat_q;
  logic [15:0]     divcnt, hcnt, vcnt;
  logic            slot_first, slot_end, frame_last, frame_wrap, frame_begin, vis_now;
  logic [PIX_W-1:0] pat_pix;

  assign slot_first  = (divcnt == 16'd0);
  assign slot_end    = (divcnt == D_LAST);
  assign frame_last  = (hcnt == H_LAST) && (vcnt == V_LAST);
  assign frame_wrap  = (state == VG_RUN) && slot_end && frame_last;
  // Pattern latch and LFSR reseed happen on the edge that puts counters at (0,0).
  assign frame_begin = enable && ((state == VG_IDLE) || frame_wrap);
  assign vis_now     = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign dbg_state   = state;

  always_comb begin
    state_nxt = state;
    case (state)
      VG_IDLE: if (enable) state_nxt = VG_RUN;
      VG_RUN:  if (frame_wrap && !enable) state_nxt = VG_IDLE;
      default: state_nxt = VG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= VG_IDLE;
    else     state <= state_nxt;
  end

`ifdef VIDGEN_LFSR_EN
  logic [11:0] lfsr_q;

  vidgen_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .seed_load (frame_begin),
    .advance   ((state == VG_RUN) && slot_first && vis_now),
    .q         (lfsr_q)
  );
`endif

  always_comb begin
    pat_pix = '0;
    case (pat_q)
      PAT_XRAMP: pat_pix = {3'b000, hcnt[8:0]};
      PAT_YRAMP: pat_pix = {3'b000, vcnt[8:0]};
      PAT_CHECK: pat_pix = (hcnt[3] ^ vcnt[3]) ? 12'hFFF : 12'h000;
`ifdef VIDGEN_LFSR_EN
      PAT_LFSR:  pat_pix = lfsr_q;
`else
      PAT_LFSR:  pat_pix = 12'hFFF;
`endif
      default:   pat_pix = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divcnt             <= '0;
      hcnt               <= '0;
      vcnt               <= '0;
      pat_q              <= PAT_XRAMP;
      vid_pixel          <= '0;
      vid_pixsync        <= 1'b0;
      vid_hblank         <= 1'b1;
      vid_vblank         <= 1'b1;
      vid_visible        <= 1'b0;
      frame_start        <= 1'b0;
      status_frame_count <= '0;
    end else begin
      if (frame_begin) pat_q <= vidgen_pattern_t'(pattern_sel);
      if (frame_wrap)  status_frame_count <= status_frame_count + 16'd1;
      if (state == VG_RUN) begin
        if (slot_end) begin
          divcnt <= '0;
          if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 16'd0 : vcnt + 16'd1;
          end else begin
            hcnt <= hcnt + 16'd1;
          end
        end else begin
          divcnt <= divcnt + 16'd1;
        end
        vid_pixsync <= slot_first;
        frame_start <= slot_first && (hcnt == 16'd0) && (vcnt == 16'd0);
        // Slot values are captured once so they hold steady for PIX_DIV clocks.
        if (slot_first) begin
          vid_hblank  <= !(hcnt < H_ACT);
          vid_vblank  <= !(vcnt < V_ACT);
          vid_visible <= vis_now;
          vid_pixel   <= vis_now ? pat_pix : 12'h000;
        end
      end else begin
        divcnt      <= '0;
        hcnt        <= '0;
        vcnt        <= '0;
        vid_pixel   <= '0;
        vid_pixsync <= 1'b0;
        vid_hblank  <= 1'b1;
        vid_vblank  <= 1'b1;
        vid_visible <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vidgen.sv
// Bench for vidgen: two instances (PIX_DIV=1 and PIX_DIV=3) on a reduced raster,
// checked slot by slot against a raster model held in expected queues.
module tb_vidgen;
  import vidgen_pkg::*;

  localparam int HA = 40, HB = 8, VA = 20, VB = 4;
  localparam int HT = HA + HB, VT = VA + VB, NSLOT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        en  [2];
  logic [1:0]  psel[2];
  logic [11:0] pix [2];
  logic        sync[2], hb[2], vb[2], vis[2], fs[2], dbg[2];
  logic [15:0] fc  [2];

  vidgen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .PIX_DIV(1)) dut0 (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .pattern_sel(psel[0]),
    .vid_pixel(pix[0]), .vid_pixsync(sync[0]), .vid_hblank(hb[0]), .vid_vblank(vb[0]),
    .vid_visible(vis[0]), .frame_start(fs[0]), .status_frame_count(fc[0]), .dbg_state(dbg[0]));

  vidgen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .PIX_DIV(3)) dut1 (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .pattern_sel(psel[1]),
    .vid_pixel(pix[1]), .vid_pixsync(sync[1]), .vid_hblank(hb[1]), .vid_vblank(vb[1]),
    .vid_visible(vis[1]), .frame_start(fs[1]), .status_frame_count(fc[1]), .dbg_state(dbg[1]));

  int n_checks = 0;
  int n_fail   = 0;
  // Record: {frame_count(only at frame start), frame_start, vblank, hblank, visible, pixel}
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          fcount[2];
  logic [15:0] prev_hv[2];
  bit          prev_rst[2] = '{1'b1, 1'b1};

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %h, required %h", name, id, $time, act, req);
    end
  endtask

  function automatic logic [11:0] lfsr_next(input logic [11:0] s);
    return {s[10:0], s[11] ^ s[5] ^ s[3] ^ s[0]};
  endfunction

  // Reference raster for a whole frame, in scan order.
  task automatic push_frame(input int id, input logic [1:0] pat, input logic [15:0] fcv);
    logic [11:0] l, p;
    logic        h, v, vs, f;
    logic [31:0] r;
    l = 12'hACE;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        h  = (x >= HA);
        v  = (y >= VA);
        vs = !h && !v;
        p  = 12'h000;
        if (vs) begin
          case (pat)
            2'd0: p = 12'(x % 512);
            2'd1: p = 12'(y % 512);
            2'd2: p = (((x / 8) % 2) != ((y / 8) % 2)) ? 12'hFFF : 12'h000;
            default: begin
`ifdef VIDGEN_LFSR_EN
              p = l;
              l = lfsr_next(l);
`else
              p = 12'hFFF;
`endif
            end
          endcase
        end
        f = (x == 0) && (y == 0);
        r = {(f ? fcv : 16'h0000), f, v, h, vs, p};
        if (id == 0) exp_q0.push_back(r);
        else         exp_q1.push_back(r);
      end
    end
  endtask

  task automatic mon(input int id);
    logic [31:0] e, a;
    logic [15:0] hv;
    bit          have;
    hv = {fs[id], vb[id], hb[id], vis[id], pix[id]};
    if (sync[id]) begin
      have = 1'b0;
      e    = '0;
      if (id == 0) begin
        if (exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
      end else begin
        if (exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
      end
      if (!have) begin
        chk("pixsync_unexpected", id, 32'd1, 32'd0);
      end else begin
        a = {(e[15] ? fc[id] : 16'h0000), hv};
        chk("slot", id, a, e);
      end
    end else if (!prev_rst[id]) begin
      chk("hold", id, {16'h0, hv}, {16'h0, 1'b0, prev_hv[id][14:0]});
    end
    prev_hv[id]  = hv;
    prev_rst[id] = rst[id];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic check_idle(input string name, input int id, input logic [15:0] req_fc);
    chk(name, id, {pix[id], sync[id], fs[id], vis[id], hb[id], vb[id], dbg[id]},
        {12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    chk({name, "_count"}, id, {16'h0, fc[id]}, {16'h0, req_fc});
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Called at posedge+1 with the DUT idle; runs nfr frames back to back.
  task automatic run_seq(input int id, input int nfr, input bit abort,
                         input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
    int         fclk, mid;
    logic [1:0] nxt;
    fclk = NSLOT * ((id == 0) ? 1 : 3);
    psel[id] = p0;
    en[id]   = 1'b1;
    push_frame(id, p0, 16'(fcount[id]));
    @(posedge clk);
    for (int f = 0; f < nfr; f++) begin
      mid = $urandom_range(1, fclk - 1);
      repeat (mid) @(posedge clk);
      #1;
      if (f == nfr - 1) begin
        if (abort) begin
          rst[id] = 1'b1;
          @(posedge clk);
          #1;
          if (id == 0) exp_q0.delete();
          else         exp_q1.delete();
          fcount[id] = 0;
          @(negedge clk);
          check_idle("rst_abort", id, 16'h0000);
          // enable is still high here: reset must keep winning
          @(posedge clk);
          @(negedge clk);
          check_idle("rst_wins", id, 16'h0000);
          @(posedge clk);
          #1;
          rst[id] = 1'b0;
          en[id]  = 1'b0;
          return;
        end
        en[id]   = 1'b0;
        psel[id] = 2'($urandom_range(0, 3));
      end else begin
        nxt = (f == 0) ? p1 : (f == 1) ? p2 : 2'($urandom_range(0, 3));
        psel[id] = nxt;
        push_frame(id, nxt, 16'(fcount[id] + f + 1));
      end
      repeat (fclk - mid) @(posedge clk);
    end
    fcount[id] += nfr;
    @(posedge clk);
    @(negedge clk);
    check_idle("idle_after_frames", id, 16'(fcount[id]));
    chk("queue_drained", id, 32'(qsize(id)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; psel[i] = 2'd0; fcount[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset", 0, 16'h0000);
    check_idle("reset", 1, 16'h0000);
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk);
    #1;

    run_seq(0, 3, 1'b0, PAT_XRAMP, PAT_CHECK, PAT_XRAMP);
    run_seq(0, 2, 1'b1, PAT_LFSR, PAT_LFSR, PAT_LFSR);
    run_seq(0, 2, 1'b0, PAT_LFSR, PAT_LFSR, PAT_LFSR);
    run_seq(0, 4, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    run_seq(1, 2, 1'b0, PAT_YRAMP, PAT_CHECK, PAT_XRAMP);
    run_seq(1, 1, 1'b1, PAT_LFSR, PAT_LFSR, PAT_LFSR);
    run_seq(1, 2, 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vidgen.md
# vidgen

Synthetic camera video source driving the same pixel stream the line-capture logic consumes: `vid_pixel`, `vid_pixsync`, `vid_hblank`, `vid_vblank`, `vid_visible`. It generates frame/line timing from counters and fills visible pixels from a selectable test pattern. It substitutes for the camera front end during bring-up and in benches, so line capture, histogram and host readout are exercised with known data.

## Interface
- `H_ACTIVE`, 320, visible pixels per line; 1..512, matching the 9-bit capture x position.
- `H_BLANK`, 32, blank pixel slots per line; ≥1.
- `V_ACTIVE`, 240, visible lines per frame; ≥1.
- `V_BLANK`, 8, blank lines per frame; ≥1.
- `PIX_DIV`, 1, clocks per pixel slot; ≥1. Use 1 with the capture block, which writes every visible clock.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request.
- `pattern_sel`  in  2  0 = x ramp, 1 = y ramp, 2 = checkerboard, 3 = LFSR noise.
- `vid_pixel`  out  12  pixel value; 0 when not visible.
- `vid_pixsync`  out  1  one-clock strobe marking each new pixel slot.
- `vid_hblank`  out  1  high in the H_BLANK slots of every line, including vblank lines.
- `vid_vblank`  out  1  high for all V_BLANK lines.
- `vid_visible`  out  1  equals !hblank && !vblank.
- `frame_start`  out  1  one-clock pulse with the first pixsync of each frame.
- `status_frame_count`  out  16  completed frames; wraps modulo 2^16.

## Operation
- All outputs are registered.
- Counters:
  - `divcnt` runs 0..PIX_DIV-1.
  - `hcnt` runs 0..H_ACTIVE+H_BLANK-1.
  - `vcnt` runs 0..V_ACTIVE+V_BLANK-1.
  - Line layout: visible first (hcnt < H_ACTIVE), then blank.
  - Frame layout: visible lines first (vcnt < V_ACTIVE), then blank lines.
- State machine:
  - IDLE: counters at 0, outputs idle. Go to RUN when `enable`=1.
  - RUN: slot advances when `divcnt` wraps. If `enable`=0 at the last slot of a frame, go to IDLE; otherwise start the next frame.
  - `enable` dropping mid-frame does not truncate the frame. The frame always completes.
- At each frame start, `pattern_sel` is latched. Changes mid-frame are ignored until the next frame.
- Patterns, with x = hcnt and y = vcnt:
  - ramp x: {3'b0, x[8:0]}.
  - ramp y: {3'b0, y[8:0]}.
  - checkerboard: 12'hFFF if x[3]^y[3], else 12'h000.
  - LFSR: 12-bit Fibonacci, polynomial x^12+x^6+x^4+x+1. Reseeded to 12'hACE at frame start; advances once per visible slot.
- At the last slot of each frame, `status_frame_count` increments.

## Timing
- Reset values:
  - `vid_pixel`=0, `vid_pixsync`=0, `frame_start`=0, `vid_visible`=0.
  - `vid_hblank`=1, `vid_vblank`=1.
  - `status_frame_count`=0.
  - State = IDLE.
- Start latency: `enable` sampled high in IDLE at edge N. Outputs after edge N+1 show slot (0,0), visible, with `vid_pixsync`=1 and `frame_start`=1.
- For each slot, pixel, blank and visible values change only on the clock where `vid_pixsync`=1, and hold for PIX_DIV clocks. With PIX_DIV=1, `vid_pixsync` stays high throughout RUN.
- Frame length is exactly (H_ACTIVE+H_BLANK)·(V_ACTIVE+V_BLANK)·PIX_DIV clocks. Back-to-back frames have no gap.
- Return to IDLE: outputs go idle on the clock after the last slot's hold completes.
- `rst` mid-frame aborts at once: reset values on the next clock, no frame-count increment.
- `rst` and `enable` asserted together: `rst` wins.

## Configuration
- Macro: `VIDGEN_LFSR_EN`.
- Defined: pattern 3 produces LFSR noise, and `vidgen_lfsr` is instantiated.
- Undefined: no LFSR logic is built, and pattern 3 outputs constant 12'hFFF in visible slots.

## Structure
- `vidgen_pkg` holds:
  - `vidgen_pattern_t` enum (PAT_XRAMP, PAT_YRAMP, PAT_CHECK, PAT_LFSR).
  - state enum (VG_IDLE, VG_RUN).
  - `VIDGEN_LFSR_SEED` = 12'hACE and the tap mask.
  - pixel width constant 12.
- Sub-module `vidgen_lfsr`: 12-bit register with `seed_load` and `advance` inputs and a `q` output.

## Test plan
- Reset, then `enable`=1, PIX_DIV=1, defaults, x ramp → line 0: visible for 320 clocks with pixel 0..319, then hblank for 32 clocks. `frame_start` pulses once, on the first clock.
- Full frame, defaults → vblank high for exactly 8·352 clocks. After the frame, `status_frame_count`=1, and the next frame starts with no gap.
- PIX_DIV=3, y ramp → `vid_pixsync` high one clock in three. On line 5 every visible pixel is 5, held for 3 clocks.
- `enable` dropped at line 100 → the frame completes through all vblank lines, then IDLE with `vid_pixsync`=0, hblank=vblank=1. `status_frame_count` increments once.
- Checkerboard, with `pattern_sel` switched to x ramp mid-frame → pixel (8,0)=12'hFFF and (0,0)=0. The ramp appears only from the next frame start.
- `rst` at line 50, and LFSR pattern (with macro) → outputs reach reset values the next clock. After restart, the first visible pixel is 12'hACE; repeated frames produce identical sequences.
